multi_cycle_adder: RTL and testbench
====================================

// Module: multi_cycle_adder
// PURPOSE
//  Parametrised sequential adder/subtractor; successor to the 8-bit combinational adder.
//  Adds WIDTH-bit operands CHUNK bits per cycle, rippling carry through a register.
//  Gives narrow, timing-friendly wide adds with signed-overflow flag and add/sub mode.
//  Valid/ready handshake on both sides, for use inside multi-cycle datapaths.
// PARAMETERS
//  WIDTH  32  operand/result width in bits
//  CHUNK  8   bits added per cycle; WIDTH % CHUNK == 0 required, N = WIDTH/CHUNK
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands/mode valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  x          in   WIDTH  operand A
//  y          in   WIDTH  operand B
//  carry_in   in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: x+y+carry_in ; 1: x-y-carry_in
//  out_valid  out  1      result valid (high only in DONE)
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result, mod 2^WIDTH
//  carry_out  out  1      carry out of MSB (sub: 1 = no borrow)
//  overflow   out  1      two's-complement signed overflow
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, chunk count=0, sum=0, carry_out=0, overflow=0,
//   out_valid=0; in_ready=1 (decoded from IDLE). Reset mid-operation aborts, no output.
//  FSM: IDLE -> ADD on in_valid&&in_ready; ADD -> DONE after chunk N-1;
//   DONE -> IDLE on out_ready. No other transitions.
//  Accept (IDLE, in_valid=1): latch x, yop = sub ? ~y : y, c = sub ? ~carry_in : carry_in;
//   clear count. x-~y-~cin identity gives x-y-cin for sub.
//  ADD: each cycle i=0..N-1: {c, part[i*CHUNK +: CHUNK]} = x_i + yop_i + c.
//   in_ready=0; in_valid ignored.
//  Latency: operands accepted at edge k -> out_valid=1 after edge k+N (N=1 when CHUNK=WIDTH).
//  Entering DONE: sum<=part, carry_out<=final c,
//   overflow<=(x[W-1]==yop[W-1]) && (part[W-1]!=x[W-1]).
//  sum/carry_out/overflow are output registers: change only on entry to DONE or reset;
//   hold previous result through IDLE/ADD.
//  DONE: out_valid=1, outputs stable while out_ready=0 (any duration). out_ready=1 ->
//   IDLE next edge; new operands accepted no earlier than the following edge.
//  out_ready outside DONE ignored. Throughput: one op per N+2 cycles max.
// TESTING  (WIDTH=32, CHUNK=8 unless noted)
//  1 x=100,y=100,cin=1,sub=0 -> sum=201,cout=0,ovf=0; out_valid exactly 4 edges after accept.
//  2 x=y=0xFFFFFFFF,cin=1 -> sum=0xFFFFFFFF,cout=1,ovf=0; x=0x7FFFFFFF,y=1,cin=0
//    -> sum=0x80000000,cout=0,ovf=1 (carry crosses every chunk boundary).
//  3 sub: x=200,y=20,cin=0 -> sum=180,cout=1; x=20,y=200 -> sum=0xFFFFFF4C,cout=0;
//    x=0x80000000,y=1 -> sum=0x7FFFFFFF,ovf=1.
//  4 Backpressure: out_ready=0 for 5 cycles in DONE, pulse in_valid -> outputs stable,
//    in_ready=0, pulse ignored; out_ready=1 -> IDLE, in_ready=1 next edge.
//  5 Reset asserted 2 cycles into ADD -> immediately out_valid=0,sum=0,cout=0,ovf=0,
//    in_ready=1; after release x=20,y=76 -> sum=96 with normal latency.
//  6 CHUNK=32: x=245,y=34,cin=1 -> sum=280, out_valid 1 edge after accept;
//    random 1000-op sweep vs {cout,sum}=x+yop+c reference model for CHUNK in {1,4,8,32}.

Source files
------------

// File: rtl/multi_cycle_adder_if.sv
// Handshake bundle for multi_cycle_adder: operand side (in_*), result side (out_*).
// master = producer/consumer around the adder, slave = the adder itself.
interface multi_cycle_adder_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid,
    output x,
    output y,
    output carry_in,
    output sub,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  carry_out,
    input  overflow
  );

  modport slave (
    input  in_valid,
    input  x,
    input  y,
    input  carry_in,
    input  sub,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output carry_out,
    output overflow
  );
endinterface

// File: rtl/multi_cycle_adder.sv
// Sequential add/sub: CHUNK bits per cycle, carry rippled through a flop.
// Ports: clk, rst_n (async, active low), bus (slave modport of multi_cycle_adder_if).
module multi_cycle_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  multi_cycle_adder_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] yop_q, yop_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK:0]   s;
  int               idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    yop_d   = yop_q;
    c_d     = c_q;
    part_d  = part_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    idx = int'(cnt_q) * CHUNK;
    s   = {1'b0, x_q[idx +: CHUNK]}
        + {1'b0, yop_q[idx +: CHUNK]}
        + {{CHUNK{1'b0}}, c_q};

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = ADD;
          x_d     = bus.x;
          // x + ~y + ~b == x - y - b (mod 2^W)
          yop_d   = bus.sub ? ~bus.y : bus.y;
          c_d     = bus.sub ^ bus.carry_in;
          cnt_d   = '0;
        end
      end
      ADD: begin
        part_d[idx +: CHUNK] = s[CHUNK-1:0];
        c_d   = s[CHUNK];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = part_d;
          cout_d  = s[CHUNK];
          ovf_d   = (x_q[WIDTH-1] == yop_q[WIDTH-1])
                 && (part_d[WIDTH-1] != x_q[WIDTH-1]);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      yop_q   <= '0;
      part_q  <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      yop_q   <= yop_d;
      part_q  <= part_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Directed + random bench for multi_cycle_adder at CHUNK = 1, 4, 8, 32.
// All four instances share operands; en selects which ones see in_valid.
module tb_multi_cycle_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  en;
  logic [31:0] x;
  logic [31:0] y;
  logic        cin;
  logic        sub;
  logic        out_ready;

  int checks;
  int failures;

  multi_cycle_adder_if #(.WIDTH(32)) b1 ();
  multi_cycle_adder_if #(.WIDTH(32)) b4 ();
  multi_cycle_adder_if #(.WIDTH(32)) b8 ();
  multi_cycle_adder_if #(.WIDTH(32)) b32 ();

  multi_cycle_adder #(.WIDTH(32), .CHUNK(1))
    u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  multi_cycle_adder #(.WIDTH(32), .CHUNK(4))
    u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  multi_cycle_adder #(.WIDTH(32), .CHUNK(8))
    u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  multi_cycle_adder #(.WIDTH(32), .CHUNK(32))
    u32 (.clk(clk), .rst_n(rst_n), .bus(b32));

  assign b1.in_valid  = in_valid & en[0];
  assign b1.x         = x;
  assign b1.y         = y;
  assign b1.carry_in  = cin;
  assign b1.sub       = sub;
  assign b1.out_ready = out_ready;

  assign b4.in_valid  = in_valid & en[1];
  assign b4.x         = x;
  assign b4.y         = y;
  assign b4.carry_in  = cin;
  assign b4.sub       = sub;
  assign b4.out_ready = out_ready;

  assign b8.in_valid  = in_valid & en[2];
  assign b8.x         = x;
  assign b8.y         = y;
  assign b8.carry_in  = cin;
  assign b8.sub       = sub;
  assign b8.out_ready = out_ready;

  assign b32.in_valid  = in_valid & en[3];
  assign b32.x         = x;
  assign b32.y         = y;
  assign b32.carry_in  = cin;
  assign b32.sub       = sub;
  assign b32.out_ready = out_ready;

  logic [3:0]  ov;
  logic [3:0]  ir;
  logic [3:0]  co;
  logic [3:0]  of;
  logic [31:0] sm [4];

  assign ov = {b32.out_valid, b8.out_valid, b4.out_valid, b1.out_valid};
  assign ir = {b32.in_ready, b8.in_ready, b4.in_ready, b1.in_ready};
  assign co = {b32.carry_out, b8.carry_out, b4.carry_out, b1.carry_out};
  assign of = {b32.overflow, b8.overflow, b4.overflow, b1.overflow};
  assign sm[0] = b1.sum;
  assign sm[1] = b4.sum;
  assign sm[2] = b8.sum;
  assign sm[3] = b32.sum;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] m,
                       input logic [31:0] xv,
                       input logic [31:0] yv,
                       input logic cv,
                       input logic sv);
    en       = m;
    x        = xv;
    y        = yv;
    cin      = cv;
    sub      = sv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(input int k, input int maxn, output int n);
    n = 0;
    while (!ov[k] && n < maxn) begin
      tick();
      n++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check8(input string t,
                        input logic [31:0] es,
                        input logic ec,
                        input logic eo);
    chk({t, "_sum"}, 64'(sm[2]), 64'(es));
    chk({t, "_cout"}, 64'(co[2]), 64'(ec));
    chk({t, "_ovf"}, 64'(of[2]), 64'(eo));
  endtask

  initial begin
    int n;
    logic [31:0] yo;
    logic        c0;
    logic [32:0] ref_v;
    logic        ref_o;

    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    en        = 4'h0;
    x         = '0;
    y         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;

    tick();
    tick();
    chk("rst_ir", 64'(ir), 64'hF);
    chk("rst_ov", 64'(ov), 64'h0);
    chk("rst_sum", 64'(sm[2]), 64'h0);
    rst_n = 1'b1;
    tick();

    // 1: basic add, latency 4
    issue(4'b0100, 32'd100, 32'd100, 1'b1, 1'b0);
    chk("t1_busy", 64'(ir[2]), 64'h0);
    chk("t1_ov0", 64'(ov[2]), 64'h0);
    wait_ov(2, 40, n);
    chk("t1_lat", 64'(n), 64'd4);
    check8("t1", 32'd201, 1'b0, 1'b0);
    release_out();
    chk("t1_ir", 64'(ir[2]), 64'h1);
    chk("t1_ovr", 64'(ov[2]), 64'h0);

    // 2: carry across every chunk
    issue(4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_ov(2, 40, n);
    check8("t2a", 32'hFFFF_FFFF, 1'b1, 1'b0);
    release_out();
    issue(4'b0100, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    wait_ov(2, 40, n);
    check8("t2b", 32'h8000_0000, 1'b0, 1'b1);
    release_out();

    // 3: subtract
    issue(4'b0100, 32'd200, 32'd20, 1'b0, 1'b1);
    wait_ov(2, 40, n);
    check8("t3a", 32'd180, 1'b1, 1'b0);
    release_out();
    issue(4'b0100, 32'd20, 32'd200, 1'b0, 1'b1);
    wait_ov(2, 40, n);
    check8("t3b", 32'hFFFF_FF4C, 1'b0, 1'b0);
    release_out();
    issue(4'b0100, 32'h8000_0000, 32'h1, 1'b0, 1'b1);
    wait_ov(2, 40, n);
    check8("t3c", 32'h7FFF_FFFF, 1'b1, 1'b1);
    release_out();

    // 4: backpressure in DONE, in_valid pulse ignored
    issue(4'b0100, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_ov(2, 40, n);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        x        = 32'h0;
        y        = 32'h5;
        in_valid = 1'b1;
        chk("t4_ir_pulse", 64'(ir[2]), 64'h0);
      end
      tick();
      in_valid = 1'b0;
    end
    chk("t4_ov", 64'(ov[2]), 64'h1);
    chk("t4_ir", 64'(ir[2]), 64'h0);
    check8("t4", 32'h2345_6789, 1'b0, 1'b0);
    release_out();
    chk("t4_ovr", 64'(ov[2]), 64'h0);
    chk("t4_irr", 64'(ir[2]), 64'h1);
    tick();
    chk("t4_idle", 64'(ir[2]), 64'h1);
    chk("t4_hold", 64'(sm[2]), 64'h2345_6789);

    // 5: async reset mid-ADD
    issue(4'b0100, 32'd1, 32'd2, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_ov", 64'(ov[2]), 64'h0);
    chk("t5_sum", 64'(sm[2]), 64'h0);
    chk("t5_cout", 64'(co[2]), 64'h0);
    chk("t5_ovf", 64'(of[2]), 64'h0);
    chk("t5_ir", 64'(ir[2]), 64'h1);
    tick();
    rst_n = 1'b1;
    tick();
    issue(4'b0100, 32'd20, 32'd76, 1'b0, 1'b0);
    wait_ov(2, 40, n);
    chk("t5_lat", 64'(n), 64'd4);
    check8("t5", 32'd96, 1'b0, 1'b0);
    release_out();

    // 6: single-chunk instance
    issue(4'b1000, 32'd245, 32'd34, 1'b1, 1'b0);
    wait_ov(3, 40, n);
    chk("t6_lat", 64'(n), 64'd1);
    chk("t6_sum", 64'(sm[3]), 64'd280);
    release_out();

    // random sweep on all four widths
    for (int t = 0; t < 1000; t++) begin
      x   = $urandom;
      y   = $urandom;
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      yo    = sub ? ~y : y;
      c0    = sub ? ~cin : cin;
      ref_v = {1'b0, x} + {1'b0, yo} + {32'h0, c0};
      ref_o = (x[31] == yo[31]) && (ref_v[31] != x[31]);
      issue(4'hF, x, y, cin, sub);
      n = 0;
      while (ov != 4'hF && n < 40) begin
        tick();
        n++;
      end
      chk("sw_done", 64'(ov), 64'hF);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("sw%0d_k%0d_sum", t, k),
            64'(sm[k]), 64'(ref_v[31:0]));
        chk($sformatf("sw%0d_k%0d_cout", t, k),
            64'(co[k]), 64'(ref_v[32]));
        chk($sformatf("sw%0d_k%0d_ovf", t, k),
            64'(of[k]), 64'(ref_o));
      end
      release_out();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
